// File: rtl/er_cfg_pkg.sv
// Shared encodings for the ER/OR bounds controller: FSM states, register
// offsets and CTRL bit positions.
package er_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] REG_ER_MIN = 3'd0;
  localparam logic [2:0] REG_ER_MAX = 3'd1;
  localparam logic [2:0] REG_OR_MIN = 3'd2;
  localparam logic [2:0] REG_OR_MAX = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [13:0] NUM_REGS  = 14'd5;

  localparam int CTRL_ARM  = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_ST0  = 2;
  localparam int CTRL_EXEC = 4;
  localparam int CTRL_ERR  = 5;
  localparam int CTRL_ABT  = 6;
  localparam int CTRL_WERR = 7;
  localparam int CTRL_IE   = 8;

endpackage

// File: rtl/er_cfg_ctrl_if.sv
// openMSP430 peripheral-bus bundle seen by the ER/OR bounds controller.
interface er_cfg_ctrl_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input  per_dout);
  modport slave  (input  per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/er_cfg_check.sv
// Combinational sanity check of programmed ER/OR bounds: ordered, ER word
// aligned, and the two regions disjoint.
module er_cfg_check (
  input  logic [15:0] i_er_min,
  input  logic [15:0] i_er_max,
  input  logic [15:0] i_or_min,
  input  logic [15:0] i_or_max,
  output logic        o_cfg_ok
);
  logic w_er_ord, w_or_ord, w_align, w_disj;

  assign w_er_ord = (i_er_min <= i_er_max);
  assign w_or_ord = (i_or_min <= i_or_max);
  assign w_align  = ~i_er_min[0] & ~i_er_max[0];
  // Ordered intervals are disjoint iff one ends before the other starts.
  assign w_disj   = (i_er_max < i_or_min) || (i_or_max < i_er_min);
  assign o_cfg_ok = w_er_ord & w_or_ord & w_align & w_disj;
endmodule

// File: rtl/er_cfg_ctrl.sv
// ER/OR bounds config registers plus arm/run/done sequencer for the
// execution-integrity monitor. Optional done interrupt: ER_CFG_IRQ_EN.
module er_cfg_ctrl
  import er_cfg_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'h00C8
) (
  input  logic        clk,
  input  logic        puc_rst,
  er_cfg_ctrl_if.slave bus,
  input  logic [15:0] pc,
  input  logic        exec,
  output logic [15:0] ER_min,
  output logic [15:0] ER_max,
  output logic [15:0] OR_min,
  output logic [15:0] OR_max,
  output logic        cfg_valid
`ifdef ER_CFG_IRQ_EN
  ,
  output logic        irq_done
`endif
);

  state_e      r_state, w_state_nxt;
  logic [15:0] r_er_min, r_er_max, r_or_min, r_or_max;
  logic        r_err, r_abt, r_werr, r_run_first;
  logic        w_err_nxt, w_abt_nxt, w_werr_nxt;
  logic        w_cfg_ok, w_ie;
  logic [13:0] w_off;
  logic        w_hit, w_wr, w_rd, w_bnd_wr, w_bnd_ok, w_werr_set;
  logic        w_ctrl_wr, w_arm, w_clr;
  logic [15:0] w_ctrl_rd, w_rdata;

  // Bus decode
  assign w_off      = bus.per_addr - BASE_ADDR;
  assign w_hit      = bus.per_en && (w_off < NUM_REGS);
  assign w_wr       = w_hit && (bus.per_we != 2'b00);
  assign w_rd       = w_hit && (bus.per_we == 2'b00);
  assign w_bnd_wr   = w_wr && (w_off[2:0] != REG_CTRL);
  assign w_bnd_ok   = w_bnd_wr && (bus.per_we == 2'b11) && (r_state == ST_IDLE);
  assign w_werr_set = w_bnd_wr && (r_state != ST_IDLE);
  assign w_ctrl_wr  = w_wr && (w_off[2:0] == REG_CTRL) && bus.per_we[0];
  assign w_arm      = w_ctrl_wr && bus.per_din[CTRL_ARM];
  assign w_clr      = w_ctrl_wr && bus.per_din[CTRL_CLR];

  er_cfg_check u_check (
    .i_er_min (r_er_min),
    .i_er_max (r_er_max),
    .i_or_min (r_or_min),
    .i_or_max (r_or_max),
    .o_cfg_ok (w_cfg_ok)
  );

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      r_er_min <= '0;
      r_er_max <= '0;
      r_or_min <= '0;
      r_or_max <= '0;
    end else if (w_bnd_ok) begin
      case (w_off[2:0])
        REG_ER_MIN: r_er_min <= bus.per_din;
        REG_ER_MAX: r_er_max <= bus.per_din;
        REG_OR_MIN: r_or_min <= bus.per_din;
        REG_OR_MAX: r_or_max <= bus.per_din;
        default:    ;
      endcase
    end
  end

`ifdef ER_CFG_IRQ_EN
  logic r_ie, r_irq;
  always_ff @(posedge clk) begin
    if (puc_rst) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= bus.per_din[CTRL_IE];
      // Tracks next state so the level drops on the same edge that leaves DONE.
      r_irq <= (w_state_nxt == ST_DONE) && (w_ctrl_wr ? bus.per_din[CTRL_IE] : r_ie);
    end
  end
  assign w_ie     = r_ie;
  assign irq_done = r_irq;
`else
  assign w_ie = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      r_state     <= ST_IDLE;
      r_err       <= 1'b0;
      r_abt       <= 1'b0;
      r_werr      <= 1'b0;
      r_run_first <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_err       <= w_err_nxt;
      r_abt       <= w_abt_nxt;
      r_werr      <= w_werr_nxt;
      r_run_first <= (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_abt_nxt   = r_abt;
    w_werr_nxt  = r_werr;
    if (w_werr_set) w_werr_nxt = 1'b1;
    if (w_clr)      w_werr_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arm) begin
          if (w_cfg_ok) begin
            w_state_nxt = ST_ARMED;
            w_err_nxt   = 1'b0;
            w_abt_nxt   = 1'b0;
          end else begin
            w_err_nxt   = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (w_clr)                  w_state_nxt = ST_IDLE;
        else if (pc == r_er_min)    w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // exec lags pc by a cycle, so the entry cycle is exempt from abort.
        if ((pc == r_er_max) && exec) begin
          w_state_nxt = ST_DONE;
        end else if (!exec && !r_run_first) begin
          w_state_nxt = ST_ARMED;
          w_abt_nxt   = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_clr) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ctrl_rd                  = '0;
    w_ctrl_rd[CTRL_ST0+1:CTRL_ST0] = r_state;
    w_ctrl_rd[CTRL_EXEC]       = exec;
    w_ctrl_rd[CTRL_ERR]        = r_err;
    w_ctrl_rd[CTRL_ABT]        = r_abt;
    w_ctrl_rd[CTRL_WERR]       = r_werr;
    w_ctrl_rd[CTRL_IE]         = w_ie;
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off[2:0])
        REG_ER_MIN: w_rdata = r_er_min;
        REG_ER_MAX: w_rdata = r_er_max;
        REG_OR_MIN: w_rdata = r_or_min;
        REG_OR_MAX: w_rdata = r_or_max;
        REG_CTRL:   w_rdata = w_ctrl_rd;
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.per_dout = w_rdata;
  assign ER_min       = r_er_min;
  assign ER_max       = r_er_max;
  assign OR_min       = r_or_min;
  assign OR_max       = r_or_max;
  assign cfg_valid    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_er_cfg_ctrl.sv
// Directed bench for er_cfg_ctrl: register reads go through a scoreboard
// queue, port observations are checked directly.
module tb_er_cfg_ctrl;
  localparam logic [13:0] BASE = 14'h00C8;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        puc_rst;
  logic [15:0] pc;
  logic        exec;
  logic [15:0] ER_min, ER_max, OR_min, OR_max;
  logic        cfg_valid;
`ifdef ER_CFG_IRQ_EN
  logic        irq_done;
`endif

  int  n_checks = 0;
  int  n_errors = 0;
  sb_t sb_q[$];

  er_cfg_ctrl_if bus();

  er_cfg_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .puc_rst   (puc_rst),
    .bus       (bus),
    .pc        (pc),
    .exec      (exec),
    .ER_min    (ER_min),
    .ER_max    (ER_max),
    .OR_min    (OR_min),
    .OR_max    (OR_max),
    .cfg_valid (cfg_valid)
`ifdef ER_CFG_IRQ_EN
    ,
    .irq_done  (irq_done)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ctrl_exp(input logic [1:0] st, input logic ex,
                                           input logic err, input logic abt, input logic werr);
    logic [15:0] v;
    v = '0;
    v[3:2] = st;
    v[4] = ex;
    v[5] = err;
    v[6] = abt;
    v[7] = werr;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d, input logic [1:0] we);
    bus.per_addr = BASE + 14'(off);
    bus.per_din  = d;
    bus.per_we   = we;
    bus.per_en   = 1'b1;
    tick();
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
  endtask

  // Expected value is queued at drive time and retired once per_dout settles.
  task automatic rd(input logic [3:0] off, input logic [15:0] exp, input string tag);
    sb_t e;
    sb_q.push_back('{tag: tag, exp: exp});
    bus.per_addr = BASE + 14'(off);
    bus.per_we   = 2'b00;
    bus.per_en   = 1'b1;
    #1;
    e = sb_q.pop_front();
    chk(e.tag, bus.per_dout, e.exp);
    bus.per_en   = 1'b0;
  endtask

  initial begin
    puc_rst      = 1'b1;
    pc           = 16'h0000;
    exec         = 1'b0;
    bus.per_addr = '0;
    bus.per_din  = '0;
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
    tick(); tick();
    puc_rst = 1'b0;
    #1;

    // Reset state
    for (int i = 0; i < 5; i++) rd(4'(i), 16'h0000, $sformatf("reset_reg%0d", i));
    chk("reset_cfg_valid", 16'(cfg_valid), 16'h0);
    chk("reset_dout_idle", bus.per_dout, 16'h0000);
`ifdef ER_CFG_IRQ_EN
    chk("reset_irq", 16'(irq_done), 16'h0);
`endif

    // Program and arm a valid configuration
    wr(0, 16'hE000, 2'b11);
    wr(1, 16'hE0FE, 2'b11);
    wr(2, 16'h0400, 2'b11);
    wr(3, 16'h04FF, 2'b11);
    chk("er_min_out", ER_min, 16'hE000);
    chk("er_max_out", ER_max, 16'hE0FE);
    chk("or_min_out", OR_min, 16'h0400);
    chk("or_max_out", OR_max, 16'h04FF);
    rd(2, 16'h0400, "rd_or_min");
    rd(5, 16'h0000, "rd_out_of_range");
    wr(4, 16'h0101, 2'b11);
    chk("arm_cfg_valid", 16'(cfg_valid), 16'h1);
`ifdef ER_CFG_IRQ_EN
    rd(4, ctrl_exp(2'd1, 0, 0, 0, 0) | 16'h0100, "arm_ctrl");
`else
    rd(4, ctrl_exp(2'd1, 0, 0, 0, 0), "arm_ctrl");
`endif

    // Normal run to DONE
    pc = 16'hE000; tick();
    rd(4, ctrl_exp(2'd2, 0, 0, 0, 0) | dut_ie(), "run_entry");
    exec = 1'b1; pc = 16'hE002; tick();
    rd(4, ctrl_exp(2'd2, 1, 0, 0, 0) | dut_ie(), "run_body");
    pc = 16'hE0FE; tick();
    rd(4, ctrl_exp(2'd3, 1, 0, 0, 0) | dut_ie(), "done");
`ifdef ER_CFG_IRQ_EN
    chk("irq_done_hi", 16'(irq_done), 16'h1);
`endif
    exec = 1'b0; pc = 16'h0000;
    wr(4, 16'h0002, 2'b11);
    rd(4, 16'h0000, "clr_to_idle");
    chk("clr_cfg_valid", 16'(cfg_valid), 16'h0);
`ifdef ER_CFG_IRQ_EN
    chk("irq_done_lo", 16'(irq_done), 16'h0);
`endif

    // Invalid configs: reversed ER, then overlapping OR
    wr(0, 16'hE100, 2'b11);
    wr(1, 16'hE000, 2'b11);
    wr(4, 16'h0001, 2'b11);
    rd(4, ctrl_exp(2'd0, 0, 1, 0, 0), "err_reversed");
    chk("err_cfg_valid", 16'(cfg_valid), 16'h0);
    wr(0, 16'hE000, 2'b11);
    wr(1, 16'hE0FE, 2'b11);
    wr(2, 16'hE080, 2'b11);
    wr(3, 16'hE0FF, 2'b11);
    wr(4, 16'h0001, 2'b11);
    rd(4, ctrl_exp(2'd0, 0, 1, 0, 0), "err_overlap");
    chk("overlap_cfg_valid", 16'(cfg_valid), 16'h0);
    wr(2, 16'h0400, 2'b11);
    wr(3, 16'h04FF, 2'b11);
    wr(4, 16'h0001, 2'b11);
    rd(4, ctrl_exp(2'd1, 0, 0, 0, 0), "rearm_clears_err");

    // Abort, re-entry, grace cycle
    pc = 16'hE000; tick();
    exec = 1'b1; pc = 16'hE002; tick();
    pc = 16'hE010; exec = 1'b0; tick();
    rd(4, ctrl_exp(2'd1, 0, 0, 1, 0), "abort_to_armed");
    pc = 16'hE000; tick();
    rd(4, ctrl_exp(2'd2, 0, 0, 1, 0), "reenter_run");
    pc = 16'hE010; tick();
    rd(4, ctrl_exp(2'd2, 0, 0, 1, 0), "entry_grace");
    tick();
    rd(4, ctrl_exp(2'd1, 0, 0, 1, 0), "abort_again");

    // Locked write and byte write
    wr(1, 16'hFFFE, 2'b11);
    chk("locked_er_max", ER_max, 16'hE0FE);
    rd(4, ctrl_exp(2'd1, 0, 0, 1, 1), "werr_set");
    wr(4, 16'h0003, 2'b11);
    rd(4, ctrl_exp(2'd0, 0, 0, 1, 0), "clr_priority_werr_clr");
    wr(0, 16'h1234, 2'b01);
    rd(0, 16'hE000, "byte_write_ignored");
    rd(4, ctrl_exp(2'd0, 0, 0, 1, 0), "byte_write_no_werr");

    // Reset from RUN
    wr(4, 16'h0001, 2'b11);
    pc = 16'hE000; tick();
    rd(4, ctrl_exp(2'd2, 0, 0, 0, 0), "run_before_reset");
    puc_rst = 1'b1; tick();
    puc_rst = 1'b0;
    rd(4, 16'h0000, "rst_ctrl");
    chk("rst_er_min", ER_min, 16'h0000);
    chk("rst_er_max", ER_max, 16'h0000);
    chk("rst_cfg_valid", 16'(cfg_valid), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // IE was written as 1 by the first ARM; it reads back only in the IRQ build.
  function automatic logic [15:0] dut_ie();
`ifdef ER_CFG_IRQ_EN
    return 16'h0100;
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
